// File: rtl/mem_pkg.sv
// Shared types and default widths for the data-memory responder.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package mem_pkg;

  typedef enum logic {
    MEM_LOAD = 1'b0,
    MEM_RUN  = 1'b1
  } mem_state_t;

  // Default widths matching the core's data port.
  localparam int MEM_SIZE       = 32;
  localparam int MEM_ADDR_WIDTH = 10;

endpackage

// File: rtl/sp_ram.sv
// Single-port word RAM, synchronous write, registered read.
// Latency: read data appears one cycle after the address; read-during-write returns old data.
// Backpressure: none, accepts one access every cycle.
module sp_ram #(
  parameter int SIZE       = 32,
  parameter int ADDR_WIDTH = 10,
  parameter int DEPTH      = 1024
) (
  input  logic                  CLK,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [SIZE-1:0]       wdata,
  output logic [SIZE-1:0]       rdata
);

  // Index only as wide as the array needs; the caller masks out-of-range accesses.
  localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [SIZE-1:0] mem [DEPTH];
  logic [IW-1:0]   idx;

  assign idx = addr[IW-1:0];

  generate
    if (IW < ADDR_WIDTH) begin : g_hi_bits
      logic unused_hi;
      assign unused_hi = ^addr[ADDR_WIDTH-1:IW];
    end
  endgenerate

  // Write port and registered read port share one address.
  always_ff @(posedge CLK) begin
    if (we) begin
      mem[idx] <= wdata;
    end
    rdata <= mem[idx];
  end

endmodule

// File: rtl/data_mem_responder.sv
// Data-port memory responder: loads an image after reset, then serves core reads/writes.
// Latency: reads return one cycle after daddr; writes complete at the same posedge.
// Backpressure: load_ready high only in LOAD; core port is never stalled in RUN.
module data_mem_responder
  import mem_pkg::*;
#(
  parameter int SIZE        = MEM_SIZE,
  parameter int ADDR_WIDTH  = MEM_ADDR_WIDTH,
  parameter int DEPTH       = 1024,
  parameter bit LOAD_ENABLE = 1'b1
) (
  input  logic                  CLK,
  input  logic                  RESET,
  input  logic [ADDR_WIDTH-1:0] daddr,
  input  logic [SIZE-1:0]       ddata_w,
  input  logic                  d_rw,
  output logic [SIZE-1:0]       ddata_r,
  input  logic                  load_valid,
  input  logic [SIZE-1:0]       load_data,
  input  logic                  load_last,
  output logic                  load_ready,
  output logic                  core_run,
  output logic                  load_overflow,
  output logic                  addr_err
);

  localparam logic [ADDR_WIDTH:0]   DEPTH_L     = (ADDR_WIDTH + 1)'(DEPTH);
  localparam logic [ADDR_WIDTH-1:0] LAST_PTR    = ADDR_WIDTH'(DEPTH - 1);
  localparam mem_state_t            RESET_STATE = LOAD_ENABLE ? MEM_LOAD : MEM_RUN;

  mem_state_t            state;
  mem_state_t            state_nxt;
  logic [ADDR_WIDTH-1:0] ptr;
  logic                  in_range;
  logic                  load_fire;
  logic                  ptr_at_end;

  logic                  ram_we;
  logic [ADDR_WIDTH-1:0] ram_addr;
  logic [SIZE-1:0]       ram_wdata;
  logic [SIZE-1:0]       ram_rdata;

  // rd_sel_q: last cycle was an in-range RUN read, so the RAM register is the answer.
  // hold_q: value to present otherwise (zero, or the previous output across a write).
  logic                  rd_sel_q;
  logic [SIZE-1:0]       hold_q;

  assign in_range   = {1'b0, daddr} < DEPTH_L;
  assign load_fire  = (state == MEM_LOAD) && load_valid;
  assign ptr_at_end = (ptr == LAST_PTR);

  // State register.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state <= RESET_STATE;
    end else begin
      state <= state_nxt;
    end
  end

  // Leave LOAD on the final word, or when the image fills the RAM.
  always_comb begin
    state_nxt = state;
    if (load_fire && (load_last || ptr_at_end)) begin
      state_nxt = MEM_RUN;
    end
  end

  // State-decoded outputs and RAM port steering (loader in LOAD, core in RUN).
  always_comb begin
    load_ready = 1'b0;
    core_run   = 1'b0;
    ram_we     = 1'b0;
    ram_addr   = daddr;
    ram_wdata  = ddata_w;
    case (state)
      MEM_LOAD: begin
        load_ready = !RESET;
        ram_we     = load_valid && !RESET;
        ram_addr   = ptr;
        ram_wdata  = load_data;
      end
      MEM_RUN: begin
        core_run = !RESET;
        ram_we   = (d_rw == 1'b1) && in_range && !RESET;
      end
      default: begin
        load_ready = 1'b0;
      end
    endcase
  end

  // Load pointer and sticky overflow flag; excess words are refused by leaving LOAD.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      ptr           <= '0;
      load_overflow <= 1'b0;
    end else if (load_fire) begin
      ptr <= ptr + ADDR_WIDTH'(1);
      if (!load_last && ptr_at_end) begin
        load_overflow <= 1'b1;
      end
    end
  end

  // Sticky flag for any core access beyond the implemented words.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      addr_err <= 1'b0;
    end else if ((state == MEM_RUN) && !in_range) begin
      addr_err <= 1'b1;
    end
  end

  // Read-data steering: RAM output after a valid read, held value across writes, else zero.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      rd_sel_q <= 1'b0;
      hold_q   <= '0;
    end else begin
      rd_sel_q <= (state == MEM_RUN) && !d_rw && in_range;
      hold_q   <= ((state == MEM_RUN) && d_rw) ? ddata_r : '0;
    end
  end

  assign ddata_r = rd_sel_q ? ram_rdata : hold_q;

  sp_ram #(
    .SIZE       (SIZE),
    .ADDR_WIDTH (ADDR_WIDTH),
    .DEPTH      (DEPTH)
  ) u_ram (
    .CLK   (CLK),
    .we    (ram_we),
    .addr  (ram_addr),
    .wdata (ram_wdata),
    .rdata (ram_rdata)
  );

endmodule
